// File: rtl/text_writer_if.sv
// text_writer_if: request/status/write-port bundle between game logic,
// the text writer and the character buffer write port.
// Handshake: clear_req/score_req are level requests that the writer samples
// only while it is idle (busy=0); a request seen on that edge is accepted,
// anything presented while busy=1 is ignored. done pulses for one cycle when
// an accepted operation finishes and err is meaningful only together with done.
// wr_en qualifies wr_addr/wr_data for exactly one buffer write per cycle.
interface text_writer_if #(
    parameter int SCORE_W = 20
);
    logic               clear_req;
    logic               score_req;
    logic [SCORE_W-1:0] score_val;
    logic [4:0]         score_row;
    logic [6:0]         score_col;
    logic               busy;
    logic               done;
    logic               err;
    logic               wr_en;
    logic [11:0]        wr_addr;
    logic [7:0]         wr_data;

    // Game-logic side: issues requests, observes status and write strobes.
    modport master (
        output clear_req, score_req, score_val, score_row, score_col,
        input  busy, done, err, wr_en, wr_addr, wr_data
    );

    // Writer side.
    modport slave (
        input  clear_req, score_req, score_val, score_row, score_col,
        output busy, done, err, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/text_writer.sv
// text_writer: sequential writer for the VGA character buffer.
// Clears the whole buffer to spaces, or converts a binary score to decimal
// (double dabble, one bit per cycle) and writes the digits MSD first at a
// given row/column. Digits falling past the last column are skipped but
// still take their cycle; writes never wrap to the next row.
// Optional build macro TEXT_WRITER_LZB_EN: leading zeros are written as
// spaces (the least significant digit is always a numeral).
module text_writer #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int DIGITS  = 6,
    parameter int SCORE_W = 20
) (
    input  logic          Clk,
    input  logic          Reset_n,
    text_writer_if.slave  bus,
    output logic [2:0]    dbg_state
);

    localparam int          ADDR_W  = 12;
    localparam int          CELLS   = COLS * ROWS;
    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          BIT_W   = $clog2(SCORE_W);
    localparam int          IDX_W   = $clog2(DIGITS);
    localparam longint      MAX_VAL = longint'(10 ** DIGITS) - 1;
    localparam logic [7:0]  SPACE   = 8'h20;
    localparam logic [7:0]  ZERO    = 8'h30;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_CONVERT = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]    dig_idx_q, dig_idx_d;
    logic [SCORE_W-1:0]  bin_q,     bin_d;
    logic [BCD_W-1:0]    bcd_q,     bcd_d;
    logic [4:0]          row_q,     row_d;
    logic [6:0]          col_q,     col_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic                wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;

    // One double-dabble step and the saturated capture value
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_step;
    logic [SCORE_W-1:0]  bin_step;
    logic [SCORE_W-1:0]  score_sat;

    // Digit emission request shared by the CONVERT->WRITE hand-off and WRITE
    logic                emit_en;
    logic [BCD_W-1:0]    emit_bcd;
    logic [IDX_W-1:0]    emit_idx;
    logic [7:0]          col_sum;
    logic                col_ok;
    logic [ADDR_W-1:0]   cell_addr;

    assign dbg_state   = state_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    // ASCII for digit idx (0 = most significant) of a packed BCD value.
    function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] bcd,
                                              input int idx);
        logic [3:0] nib;
        logic       lead_zero;
        nib       = bcd[BCD_W-4-4*idx +: 4];
        lead_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j <= idx && bcd[BCD_W-4-4*j +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
`ifdef TEXT_WRITER_LZB_EN
        if (lead_zero && idx < DIGITS - 1) begin
            return SPACE;
        end
`endif
        return ZERO + {4'd0, nib};
    endfunction

    // Shift-add-3 step: adjust every BCD nibble >= 5, then shift in the next bit
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
            end
        end
        bcd_step  = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
        bin_step  = {bin_q[SCORE_W-2:0], 1'b0};
        score_sat = bus.score_val;
        if (64'(bus.score_val) > MAX_VAL) begin
            score_sat = SCORE_W'(MAX_VAL);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        dig_idx_d  = dig_idx_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        row_d      = row_q;
        col_d      = col_q;
        err_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        emit_en    = 1'b0;
        emit_bcd   = bcd_q;
        emit_idx   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.clear_req) begin
                    state_d    = S_CLEAR;
                    addr_cnt_d = '0;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = SPACE;
                end else if (bus.score_req) begin
                    row_d = bus.score_row;
                    col_d = bus.score_col;
                    if (bus.score_row >= 5'(ROWS)) begin
                        // Off-screen row: reject without touching the buffer
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_CONVERT;
                        bin_d     = score_sat;
                        bcd_d     = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_CLEAR: begin
                if (addr_cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = addr_cnt_d;
                    wr_data_d  = SPACE;
                end
            end
            S_CONVERT: begin
                bcd_d     = bcd_step;
                bin_d     = bin_step;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_W'(SCORE_W - 1)) begin
                    // Last shift: the MSD is emitted straight from the step result
                    state_d   = S_WRITE;
                    dig_idx_d = '0;
                    emit_en   = 1'b1;
                    emit_bcd  = bcd_step;
                    emit_idx  = '0;
                end
            end
            S_WRITE: begin
                if (dig_idx_q == IDX_W'(DIGITS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    dig_idx_d = dig_idx_q + 1'b1;
                    emit_en   = 1'b1;
                    emit_bcd  = bcd_q;
                    emit_idx  = dig_idx_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Column/address of the emitted digit; past the last column the
        // cycle is spent with the strobe held low.
        col_sum   = {1'b0, col_q} + 8'(emit_idx);
        col_ok    = (col_sum < 8'(COLS));
        cell_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_sum);
        if (emit_en && col_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr;
            wr_data_d = digit_char(emit_bcd, int'(emit_idx));
        end

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            addr_cnt_q <= '0;
            bit_cnt_q  <= '0;
            dig_idx_q  <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            dig_idx_q  <= dig_idx_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            row_q      <= row_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed plus randomized checks of text_writer against a
// behavioural model (decimal arithmetic on the score, cell list for clear).
module tb_text_writer;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int DIGITS  = 6;
    localparam int SCORE_W = 20;
    localparam int CELLS   = COLS * ROWS;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [2:0] dbg_state;

    text_writer_if #(.SCORE_W(SCORE_W)) bus();

    text_writer #(
        .COLS(COLS), .ROWS(ROWS), .DIGITS(DIGITS), .SCORE_W(SCORE_W)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] cyc;
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    int   done_at[$];
    logic done_err[$];
    logic busy_at [0:4095];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Character expected at digit position i (0 = most significant).
    function automatic logic [7:0] exp_char(input int sat, input int i);
        int p = 1;
        for (int k = 0; k < DIGITS - 1 - i; k++) p = p * 10;
`ifdef TEXT_WRITER_LZB_EN
        if (i < DIGITS - 1 && sat < p) return 8'h20;
`endif
        return 8'(8'h30 + (sat / p) % 10);
    endfunction

    task automatic push_exp(input int cyc, input int addr, input logic [7:0] data);
        wr_t w;
        w.cyc  = 16'(cyc);
        w.addr = 12'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic build_clear();
        exp_q.delete();
        for (int a = 0; a < CELLS; a++) push_exp(a + 1, a, 8'h20);
    endtask

    task automatic build_score(input int val, input int row, input int col,
                               output int dcyc, output bit e);
        int sat;
        exp_q.delete();
        if (row >= ROWS) begin
            dcyc = 1;
            e    = 1'b1;
            return;
        end
        sat = (val > 999999) ? 999999 : val;
        for (int i = 0; i < DIGITS; i++) begin
            if (col + i < COLS) push_exp(21 + i, row * COLS + col + i, exp_char(sat, i));
        end
        dcyc = 27;
        e    = 1'b0;
    endtask

    // Present a request on the next edge and log ncyc cycles after it.
    task automatic run_op(input bit clr, input bit scr, input logic [19:0] val,
                          input logic [4:0] row, input logic [6:0] col,
                          input int ncyc, input int pulse_at);
        wr_t w;
        got_q.delete();
        done_at.delete();
        done_err.delete();
        bus.clear_req = clr;
        bus.score_req = scr;
        bus.score_val = val;
        bus.score_row = row;
        bus.score_col = col;
        @(posedge Clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge Clk);
            busy_at[n] = bus.busy;
            if (bus.wr_en) begin
                w.cyc  = 16'(n);
                w.addr = bus.wr_addr;
                w.data = bus.wr_data;
                got_q.push_back(w);
            end
            if (bus.done) begin
                done_at.push_back(n);
                done_err.push_back(bus.err);
            end
            bus.clear_req = 1'b0;
            bus.score_req = (n == pulse_at);
            if (n == pulse_at) bus.score_val = 20'd777;
        end
        bus.score_req = 1'b0;
    endtask

    task automatic cmp_run(input string tag, input int exp_done, input bit exp_err);
        chk({tag, " write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, " write{cyc,addr,data}"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        chk({tag, " done_count"}, 64'(done_at.size()), 64'd1);
        if (done_at.size() > 0) begin
            chk({tag, " done_cycle"}, 64'(done_at[0]), 64'(exp_done));
            chk({tag, " err"}, 64'(done_err[0]), 64'(exp_err));
        end
        chk({tag, " busy_cycle1"}, 64'(busy_at[1]), 64'd1);
        chk({tag, " idle_after_done"}, 64'(busy_at[exp_done + 1]), 64'd0);
    endtask

    task automatic score_case(input string tag, input int val, input int row,
                              input int col, input int ncyc, input int pulse_at);
        int dcyc;
        bit e;
        build_score(val, row, col, dcyc, e);
        run_op(1'b0, 1'b1, 20'(val), 5'(row), 7'(col), ncyc, pulse_at);
        cmp_run(tag, dcyc, e);
    endtask

    initial begin
        int  k;
        bit  seen_done;
        int  v;
        bus.clear_req = 1'b0;
        bus.score_req = 1'b0;
        bus.score_val = '0;
        bus.score_row = '0;
        bus.score_col = '0;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset values
        chk("rst busy",    64'(bus.busy),    64'd0);
        chk("rst done",    64'(bus.done),    64'd0);
        chk("rst err",     64'(bus.err),     64'd0);
        chk("rst wr_en",   64'(bus.wr_en),   64'd0);
        chk("rst wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst wr_data", 64'(bus.wr_data), 64'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Full clear
        build_clear();
        run_op(1'b1, 1'b0, '0, '0, '0, 2403, -1);
        cmp_run("clear", 2401, 1'b0);

        // Directed score writes
        score_case("score1234", 1234, 2, 10, 30, -1);
        score_case("saturate_edge", 1048575, 29, 77, 30, -1);
        score_case("reject_row30", 5, 30, 0, 30, -1);
        chk("reject idle_cycle2", 64'(busy_at[2]), 64'd0);
        score_case("zero", 0, 0, 0, 30, -1);

        // Priority: both requests together take the clear only
        build_clear();
        run_op(1'b1, 1'b1, 20'd1234, 5'd2, 7'd10, 2403, -1);
        cmp_run("priority", 2401, 1'b0);

        // score_req pulsed during CONVERT is ignored
        score_case("ignored_req", 1234, 2, 10, 45, 5);

        // Back-to-back: accepted in the first IDLE cycle after DONE
        score_case("b2b_first", 42, 0, 0, 28, -1);
        score_case("b2b_second", 999, 1, 75, 30, -1);

        // Randomized score requests
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(0, 999999));
                2:       v = int'($urandom_range(1000000, 1048575));
                default: v = int'($urandom_range(0, 1048575));
            endcase
            score_case($sformatf("rand%0d", r), v, int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 127)), 30, -1);
        end

        // Reset in the middle of a clear
        bus.clear_req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus.clear_req = 1'b0;
        k = 0;
        while (!(bus.wr_en && bus.wr_addr == 12'd100) && k < 300) begin
            @(negedge Clk);
            k++;
        end
        chk("midclear reached_addr100", 64'(bus.wr_en && bus.wr_addr == 12'd100), 64'd1);
        #1 Reset_n = 1'b0;
        #1;
        chk("midclear wr_en_low", 64'(bus.wr_en), 64'd0);
        chk("midclear busy_low",  64'(bus.busy),  64'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (bus.done) seen_done = 1'b1;
        end
        Reset_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge Clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        chk("midclear no_done_or_resume", 64'(seen_done), 64'd0);
        build_clear();
        run_op(1'b1, 1'b0, '0, '0, '0, 2403, -1);
        cmp_run("clear_after_reset", 2401, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_writer.md
# text_writer

Sequential writer for the character text buffer read by the VGA text renderer. On request it either sweeps the whole buffer to spaces (clear) or converts a binary score into decimal ASCII digits and writes them into consecutive buffer cells at a given row/column. It sits between game logic and the buffer's write port. The renderer reads the same buffer and looks up glyphs in the font ROM.

## Interface
- COLS, 80, text columns per row
- ROWS, 30, text rows
- DIGITS, 6, decimal digits written per score request
- SCORE_W, 20, score input width
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  request full-buffer clear; sampled in IDLE only
- score_req  in  1  request score write; sampled in IDLE only
- score_val  in  SCORE_W  binary score, captured on accept
- score_row  in  5  target row, captured on accept
- score_col  in  7  column of the most significant digit, captured on accept
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when an operation completes
- err  out  1  valid with done; 1 = score request rejected
- wr_en  out  1  buffer write strobe
- wr_addr  out  12  cell address = row*COLS + col
- wr_data  out  8  ASCII code

## Operation
- States: IDLE, CLEAR, CONVERT, WRITE, DONE.
- IDLE: clear_req has priority. If clear_req and score_req are both high, the clear is taken and the score request is dropped.
- Requests arriving while busy are ignored. They are not queued.
- CLEAR: writes 0x20 to addresses 0 through COLS*ROWS-1 in ascending order, one write per cycle, then goes to DONE with err=0.
- Score accept with score_row >= ROWS: go directly to DONE with err=1. No writes occur.
- CONVERT: iterative shift-add-3 (double dabble), one input bit per cycle, SCORE_W cycles. Input above 999999 saturates to 999999 before conversion.
- WRITE: DIGITS cycles, most significant digit first.
  - Digit i goes to col = score_col+i, with wr_data = 0x30 + digit.
  - If score_col+i >= COLS, wr_en stays low for that cycle, but the cycle is still consumed. The write never wraps to the next row.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic: wr_addr is computed at full 12-bit width with no truncation. The maximum address is 2399.

## Timing
- Reset values: busy=0, done=0, err=0, wr_en=0, wr_addr=0, wr_data=0x00, state IDLE.
- All outputs are registered.
- Accept edge = cycle 0; busy=1 from cycle 1.
- Clear: wr_en high on cycles 1 through 2400; done on cycle 2401; busy=0 on cycle 2402.
- Score: CONVERT on cycles 1 through 20; writes on cycles 21 through 26; done on cycle 27; IDLE on cycle 28.
- Rejected score: done=1 and err=1 on cycle 1; IDLE on cycle 2.
- A new request can be accepted in the first IDLE cycle after DONE.
- Reset_n low at any point forces IDLE immediately and asynchronously, with wr_en low. The interrupted operation is abandoned, not resumed, and no done is issued.

## Configuration
- TEXT_WRITER_LZB_EN (leading-zero blanking):
  - Defined: leading zero digits are written as 0x20. The least significant digit is always a numeral. Example: 42 writes as "    42".
  - Undefined: all DIGITS digits are written as numerals. Example: 42 writes as "000042".
- Cycle counts are identical in both builds.

## Test plan
- Reset: assert Reset_n=0 mid-CLEAR at address 100. Required: wr_en=0 and busy=0 immediately; no done; after release, the next clear_req restarts at address 0.
- Clear: clear_req for one cycle. Required: 2400 writes of 0x20 to addresses 0 through 2399 in order; done on cycle 2401 with err=0.
- Score write: score_val=1234, row=2, col=10. Required: addresses 170 through 175 receive "001234" (0x30,0x30,0x31,0x32,0x33,0x34). With TEXT_WRITER_LZB_EN, they receive 0x20,0x20,0x31,0x32,0x33,0x34. done on cycle 27.
- Saturation and edge: score_val=1048575, row=29, col=77. Required: "999" written to addresses 2397 through 2399; wr_en low on cycles 24 through 26; done on cycle 27.
- Reject and priority:
  - score_row=30: done with err=1 on cycle 1 and zero writes.
  - clear_req and score_req high together: clear only.
- Ignored request: score_req pulsed during CONVERT. Required: no effect on the writes in flight; no second done.
